// File: rtl/cache_pkg.sv
// Shared defaults and types for the main memory model and its storage array.
package cache_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } mem_state_t;

   typedef struct packed {
      logic ren;
      logic wen;
      logic err;
   } mem_op_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM: synchronous write, registered read with an output register.
module mem_array
   import cache_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MEM_WORDS  = 1024,
   parameter int IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic                  re,
   input  logic [IDX_W-1:0]      addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS] = '{default: '0};

   // NOTE: storage has no reset branch so rst never disturbs its contents; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[addr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= r_mem[addr];
      end
   end

endmodule

// File: rtl/main_memory.sv
// Fixed-latency main memory model: accepts one request in IDLE, waits LATENCY cycles, responds for one cycle.
module main_memory
   import cache_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int MEM_WORDS  = 1024,
   parameter int LATENCY    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_ren,
   input  logic                  mem_wen,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_din,
   output logic [DATA_WIDTH-1:0] mem_dout,
   output logic                  mem_rdy,
   output logic                  mem_valid,
   output logic                  mem_err
);

   localparam int         IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

   mem_state_t            r_state, w_state_nxt;
   logic [7:0]            r_cnt;
   logic [IDX_W-1:0]      r_idx;
   logic [DATA_WIDTH-1:0] r_din;
   mem_op_t               r_op;

   logic                  w_accept, w_enter_done, w_req_err;
   mem_op_t               w_op;
   logic [IDX_W-1:0]      w_idx;
   logic [DATA_WIDTH-1:0] w_din;
   logic                  w_we, w_re;

   function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-3:0] idx;
      idx = a[ADDR_WIDTH-1:2];
      return (a[1:0] != 2'b00) || (64'(idx) >= 64'(MEM_WORDS));
   endfunction

   assign w_req_err = (mem_ren & mem_wen) | addr_err(mem_addr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
   always_comb begin
      w_state_nxt  = r_state;
      w_accept     = 1'b0;
      w_enter_done = 1'b0;
      mem_rdy      = 1'b0;
      mem_valid    = 1'b0;
      mem_err      = 1'b0;
      case (r_state)
         IDLE: begin
            mem_rdy = 1'b1;
            if (mem_ren | mem_wen) begin
               w_accept = 1'b1;
               if (LATENCY == 1) begin
                  w_state_nxt  = DONE;
                  w_enter_done = 1'b1;
               end else begin
                  w_state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (r_cnt == 8'd0) begin
               w_state_nxt  = DONE;
               w_enter_done = 1'b1;
            end
         end
         DONE: begin
            mem_valid   = 1'b1;
            mem_err     = r_op.err;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // In IDLE the live request drives the array so a LATENCY=1 access completes on its acceptance edge.
   always_comb begin
      if (r_state == IDLE) begin
         w_op  = '{ren: mem_ren, wen: mem_wen, err: w_req_err};
         w_idx = mem_addr[IDX_W+1:2];
         w_din = mem_din;
      end else begin
         w_op  = r_op;
         w_idx = r_idx;
         w_din = r_din;
      end
   end

   assign w_we = w_enter_done & w_op.wen & ~w_op.err;
   assign w_re = w_enter_done & w_op.ren & ~w_op.err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_idx <= '0;
         r_din <= '0;
         r_op  <= '0;
      end else if (w_accept) begin
         r_cnt <= LAT_M1;
         r_idx <= w_idx;
         r_din <= w_din;
         r_op  <= w_op;
      end else if (r_state == WAIT && r_cnt != 8'd0) begin
         r_cnt <= r_cnt - 8'd1;
      end
   end

   mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_WORDS  (MEM_WORDS),
      .IDX_W      (IDX_W)
   ) u_mem_array (
      .clk   (clk),
      .rst   (rst),
      .we    (w_we),
      .re    (w_re),
      .addr  (w_idx),
      .wdata (w_din),
      .rdata (mem_dout)
   );

endmodule

// File: tb/tb_main_memory.sv
// Self-checking bench for main_memory: LATENCY=4 instance driven from a vector table, LATENCY=1 instance back-to-back.
module tb_main_memory;

   localparam int DW   = 32;
   localparam int AW   = 32;
   localparam int LAT4 = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          ren = 1'b0, wen = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] din = '0, dout;
   logic          rdy, valid, err;

   logic          b_ren = 1'b0, b_wen = 1'b0;
   logic [AW-1:0] b_addr = '0;
   logic [DW-1:0] b_din = '0, b_dout;
   logic          b_rdy, b_valid, b_err;

   main_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_WORDS(1024), .LATENCY(LAT4)) dut4 (
      .clk(clk), .rst(rst), .mem_ren(ren), .mem_wen(wen), .mem_addr(addr), .mem_din(din),
      .mem_dout(dout), .mem_rdy(rdy), .mem_valid(valid), .mem_err(err)
   );

   main_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_WORDS(1024), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .mem_ren(b_ren), .mem_wen(b_wen), .mem_addr(b_addr), .mem_din(b_din),
      .mem_dout(b_dout), .mem_rdy(b_rdy), .mem_valid(b_valid), .mem_err(b_err)
   );

   typedef struct {
      int            cyc;
      logic          err;
      logic [DW-1:0] dout;
   } exp_t;

   typedef struct {
      logic          ren;
      logic          wen;
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
      logic          err;
      logic [DW-1:0] dout;
   } vec_t;

   exp_t sb4[$];
   exp_t sb1[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
   endtask

   // Response monitors: pop the scoreboard on every valid strobe, else mem_err must be low.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (valid) begin
            if (sb4.size() == 0) begin
               check("lat4_unexpected_valid", 64'(valid), 64'd0);
            end else begin
               e = sb4.pop_front();
               check("lat4_cycle", 64'(cyc), 64'(e.cyc));
               check("lat4_err", 64'(err), 64'(e.err));
               check("lat4_dout", 64'(dout), 64'(e.dout));
            end
         end else begin
            check("lat4_err_without_valid", 64'(err), 64'd0);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (b_valid) begin
            if (sb1.size() == 0) begin
               check("lat1_unexpected_valid", 64'(b_valid), 64'd0);
            end else begin
               e = sb1.pop_front();
               check("lat1_cycle", 64'(cyc), 64'(e.cyc));
               check("lat1_err", 64'(b_err), 64'(e.err));
               check("lat1_dout", 64'(b_dout), 64'(e.dout));
            end
         end else begin
            check("lat1_err_without_valid", 64'(b_err), 64'd0);
         end
      end
   end

   task automatic drain(input bit lat1);
      int guard = 0;
      do begin
         @(negedge clk);
         #1;
         guard++;
      end while (((lat1 ? sb1.size() : sb4.size()) != 0) && guard < 50);
      if ((lat1 ? sb1.size() : sb4.size()) != 0) begin
         timeout(lat1 ? "drain_lat1" : "drain_lat4");
         if (lat1) sb1.delete();
         else sb4.delete();
      end
      @(negedge clk);
   endtask

   // One LATENCY=4 transaction; on return the bench sits on a negedge with the block back in IDLE.
   task automatic req4(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic e_err, input logic [DW-1:0] e_dout);
      exp_t e;
      int   guard = 0;
      while (!rdy && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!rdy) begin
         timeout("req4_rdy");
         return;
      end
      ren = r; wen = w; addr = a; din = d;
      e.cyc = cyc + 1 + LAT4; e.err = e_err; e.dout = e_dout;
      sb4.push_back(e);
      @(negedge clk);
      ren = 1'b0; wen = 1'b0;
      drain(1'b0);
      check("lat4_rdy_after_done", 64'(rdy), 64'd1);
   endtask

   vec_t vecs[12];

   initial begin
      exp_t e;

      vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
      vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
      vecs[2]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
      vecs[3]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
      vecs[4]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0001, 1'b1, 32'hDEAD_BEEF};
      vecs[5]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h0000_0000};
      vecs[6]  = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h1234_5678, 1'b0, 32'h0000_0000};
      vecs[7]  = '{1'b0, 1'b1, 32'h0000_0004, 32'hCAFE_F00D, 1'b0, 32'h0000_0000};
      vecs[8]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0000_0000, 1'b0, 32'h1234_5678};
      vecs[9]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0000_0077, 1'b1, 32'h1234_5678};
      vecs[10] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000};
      vecs[11] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};

      #1;
      check("reset_rdy", 64'(rdy), 64'd1);
      check("reset_valid", 64'(valid), 64'd0);
      check("reset_err", 64'(err), 64'd0);
      check("reset_dout", 64'(dout), 64'd0);
      @(negedge clk);
      @(negedge clk);
      check("reset_held_rdy", 64'(rdy), 64'd1);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         req4(vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].din, vecs[i].err, vecs[i].dout);
      end

      // Busy-ignore: a write held while the block is busy must leave no trace.
      ren = 1'b1; addr = 32'h10;
      e.cyc = cyc + 1 + LAT4; e.err = 1'b0; e.dout = 32'hDEAD_BEEF;
      sb4.push_back(e);
      @(negedge clk);
      ren = 1'b0; wen = 1'b1; addr = 32'h14; din = 32'h55;
      check("busy_rdy_low", 64'(rdy), 64'd0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      wen = 1'b0;
      drain(1'b0);
      req4(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 32'h0000_0000);

      // Reset mid-operation: the write is aborted, no response appears.
      wen = 1'b1; addr = 32'h30; din = 32'hA5A5_A5A5;
      @(negedge clk);
      wen = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_rdy", 64'(rdy), 64'd1);
      check("midrst_valid", 64'(valid), 64'd0);
      check("midrst_err", 64'(err), 64'd0);
      check("midrst_dout", 64'(dout), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < LAT4 + 3; i++) @(negedge clk);
      req4(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'h0000_0000);

      // LATENCY=1 back-to-back: requests held continuously, one accepted every two cycles.
      b_wen = 1'b1; b_addr = 32'h0; b_din = 32'h1111_1111;
      e.cyc = cyc + 1; e.err = 1'b0; e.dout = 32'h0;
      sb1.push_back(e);
      @(negedge clk);
      check("lat1_busy_in_done", 64'(b_rdy), 64'd0);
      b_addr = 32'h4; b_din = 32'h2222_2222;
      e.cyc = cyc + 2; e.err = 1'b0; e.dout = 32'h0;
      sb1.push_back(e);
      @(negedge clk);
      @(negedge clk);
      b_wen = 1'b0;
      drain(1'b1);

      b_ren = 1'b1; b_addr = 32'h0;
      e.cyc = cyc + 1; e.err = 1'b0; e.dout = 32'h1111_1111;
      sb1.push_back(e);
      @(negedge clk);
      b_addr = 32'h4;
      e.cyc = cyc + 2; e.err = 1'b0; e.dout = 32'h2222_2222;
      sb1.push_back(e);
      @(negedge clk);
      @(negedge clk);
      b_ren = 1'b0;
      drain(1'b1);
      @(negedge clk);
      check("lat1_dout_hold", 64'(b_dout), 64'h2222_2222);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1, "watchdog");
   end

endmodule
